// File: rtl/fm7_video_pkg.sv
// Shared definitions for the FM-7 video pipeline: palette FSM states, the
// plane byte width and the power-on palette pattern.
package fm7_video_pkg;

  localparam int PLANE_W = 8;

  typedef enum logic {
    INIT,
    RUN
  } pal_state_t;

  // Bit bit_pos of the default entry for palette index idx, layout {G,R,B},
  // each component COMP_W bits wide. B follows idx[0], R idx[1], G idx[2].
  function automatic logic pal_default(input int idx, input int comp_w, input int bit_pos);
    return idx[bit_pos / comp_w];
  endfunction

endpackage

// File: rtl/plane_shifter.sv
// One bitplane shift register: clear has priority over load, load over shift,
// and both load and shift advance only on the pixel enable.
module plane_shifter
  import fm7_video_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_clr,
  input  logic               i_ce,
  input  logic               i_load,
  input  logic [PLANE_W-1:0] i_data,
  output logic               o_msb
);

  logic [PLANE_W-1:0] r_sft;

  // NOTE: sequential state is only ever updated with non-blocking assignments.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sft <= '0;
    end else if (i_clr) begin
      r_sft <= '0;
    end else if (i_ce && i_load) begin
      r_sft <= i_data;
    end else if (i_ce) begin
      r_sft <= {r_sft[PLANE_W-2:0], 1'b0};
    end
  end

  assign o_msb = r_sft[PLANE_W-1];

endmodule

// File: rtl/plane_palette_shifter.sv
// Bitplane shifters feeding a CPU-writable colour palette; the plane bits of
// each pixel index the palette and the looked-up colour is registered to the DAC.
module plane_palette_shifter
  import fm7_video_pkg::*;
#(
  parameter int PLANES  = 3,
  parameter int COMP_W  = 1,
  parameter int ENTRY_W = 3 * COMP_W
) (
  input  logic                      CLKSYS,
  input  logic                      RESETBn,
  input  logic                      PIXCE,
  input  logic                      SFTLOD,
  input  logic                      SVDOFFn,
  input  logic                      SBLANKn,
  input  logic [PLANES-1:0]         PLANE_DIS,
  input  logic [PLANE_W*PLANES-1:0] VDATA,
  input  logic                      PAL_WR,
  input  logic                      PAL_RD,
  input  logic [PLANES-1:0]         PAL_ADDR,
  input  logic [ENTRY_W-1:0]        PAL_WDATA,
  output logic [ENTRY_W-1:0]        PAL_RDATA,
  output logic                      PAL_RVALID,
  output logic                      PAL_BUSY,
  output logic [PLANES-1:0]         PIXIDX,
  output logic [ENTRY_W-1:0]        COLOR
);

  localparam int DEPTH = 2 ** PLANES;

  pal_state_t          r_state;
  logic [PLANES-1:0]   r_idx;
  logic                r_busy;
  logic [ENTRY_W-1:0]  r_pal [DEPTH];
  logic [ENTRY_W-1:0]  r_rdata;
  logic                r_rvalid;
  logic [PLANES-1:0]   r_pixidx;
  logic [ENTRY_W-1:0]  r_color;

  logic [ENTRY_W-1:0]  w_def;
  logic                w_clr;
  logic [PLANES-1:0]   w_msb;

  always_comb begin
    w_def = '0;
    for (int b = 0; b < ENTRY_W; b++) begin
      w_def[b] = pal_default(int'(r_idx), COMP_W, b);
    end
  end

  // Init sweep: one default entry per cycle, BUSY drops together with the move to RUN.
  always_ff @(posedge CLKSYS or negedge RESETBn) begin
    if (!RESETBn) begin
      r_state <= INIT;
      r_idx   <= '0;
      r_busy  <= 1'b1;
    end else if (r_state == INIT) begin
      r_idx <= r_idx + PLANES'(1);
      if (r_idx == PLANES'(DEPTH - 1)) begin
        r_state <= RUN;
        r_busy  <= 1'b0;
      end
    end
  end

  // NOTE: the palette flops carry no reset; the init sweep rewrites every entry after reset.
  always_ff @(posedge CLKSYS) begin
    if (r_state == INIT) begin
      r_pal[r_idx] <= w_def;
    end else if (PAL_WR) begin
      r_pal[PAL_ADDR] <= PAL_WDATA;
    end
  end

  // Reads and the colour lookup sample the array before this edge's write (read-first).
  always_ff @(posedge CLKSYS or negedge RESETBn) begin
    if (!RESETBn) begin
      r_rdata  <= '0;
      r_rvalid <= 1'b0;
      r_pixidx <= '0;
      r_color  <= '0;
    end else begin
      r_rvalid <= PAL_RD;
      if (PAL_RD) begin
        r_rdata <= r_pal[PAL_ADDR];
      end
      if (PIXCE) begin
        r_pixidx <= w_msb;
        r_color  <= r_pal[r_pixidx];
      end
    end
  end

  assign w_clr = ~(SVDOFFn & SBLANKn);

  for (genvar p = 0; p < PLANES; p++) begin : g_plane
    plane_shifter u_shifter (
      .clk    (CLKSYS),
      .rst_n  (RESETBn),
      .i_clr  (w_clr | PLANE_DIS[p]),
      .i_ce   (PIXCE),
      .i_load (SFTLOD),
      .i_data (VDATA[PLANE_W*p +: PLANE_W]),
      .o_msb  (w_msb[p])
    );
  end

  assign PAL_RDATA  = r_rdata;
  assign PAL_RVALID = r_rvalid;
  assign PAL_BUSY   = r_busy;
  assign PIXIDX     = r_pixidx;
  assign COLOR      = r_color;

endmodule

// File: tb/tb_plane_palette_shifter.sv
// Self-checking bench for plane_palette_shifter (PLANES=3, COMP_W=4): directed
// scenarios plus random traffic compared against a pixel/palette reference model.
module tb_plane_palette_shifter;

  localparam int PLANES  = 3;
  localparam int COMP_W  = 4;
  localparam int ENTRY_W = 12;
  localparam int DEPTH   = 8;

  logic                CLKSYS = 1'b0;
  logic                RESETBn;
  logic                PIXCE;
  logic                SFTLOD;
  logic                SVDOFFn;
  logic                SBLANKn;
  logic [PLANES-1:0]   PLANE_DIS;
  logic [8*PLANES-1:0] VDATA;
  logic                PAL_WR;
  logic                PAL_RD;
  logic [PLANES-1:0]   PAL_ADDR;
  logic [ENTRY_W-1:0]  PAL_WDATA;
  logic [ENTRY_W-1:0]  PAL_RDATA;
  logic                PAL_RVALID;
  logic                PAL_BUSY;
  logic [PLANES-1:0]   PIXIDX;
  logic [ENTRY_W-1:0]  COLOR;

  always #5 CLKSYS = ~CLKSYS;

  plane_palette_shifter #(
    .PLANES  (PLANES),
    .COMP_W  (COMP_W),
    .ENTRY_W (ENTRY_W)
  ) dut (
    .CLKSYS     (CLKSYS),
    .RESETBn    (RESETBn),
    .PIXCE      (PIXCE),
    .SFTLOD     (SFTLOD),
    .SVDOFFn    (SVDOFFn),
    .SBLANKn    (SBLANKn),
    .PLANE_DIS  (PLANE_DIS),
    .VDATA      (VDATA),
    .PAL_WR     (PAL_WR),
    .PAL_RD     (PAL_RD),
    .PAL_ADDR   (PAL_ADDR),
    .PAL_WDATA  (PAL_WDATA),
    .PAL_RDATA  (PAL_RDATA),
    .PAL_RVALID (PAL_RVALID),
    .PAL_BUSY   (PAL_BUSY),
    .PIXIDX     (PIXIDX),
    .COLOR      (COLOR)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: palette contents, plane bytes as integers, pixel pipeline.
  logic [ENTRY_W-1:0] m_pal [DEPTH];
  int                 m_sft [PLANES];
  logic [PLANES-1:0]  m_idx;
  logic [ENTRY_W-1:0] m_color;
  logic [ENTRY_W-1:0] m_rdata;
  logic               m_rvalid;
  logic               m_busy;
  int                 m_init;

  function automatic logic [ENTRY_W-1:0] def_color(input logic [2:0] i);
    return {{4{i[2]}}, {4{i[1]}}, {4{i[0]}}};
  endfunction

  task automatic model_reset();
    for (int p = 0; p < PLANES; p++) m_sft[p] = 0;
    m_idx    = '0;
    m_color  = '0;
    m_rdata  = '0;
    m_rvalid = 1'b0;
    m_busy   = 1'b1;
    m_init   = 0;
  endtask

  task automatic model_edge();
    logic [ENTRY_W-1:0] old_pal [DEPTH];
    logic clr;
    old_pal = m_pal;
    if (PAL_RD) m_rdata = old_pal[PAL_ADDR];
    m_rvalid = PAL_RD;
    if (m_busy) begin
      m_pal[m_init] = def_color(3'(m_init));
      if (m_init == DEPTH - 1) m_busy = 1'b0;
      m_init++;
    end else if (PAL_WR) begin
      m_pal[PAL_ADDR] = PAL_WDATA;
    end
    clr = !(SVDOFFn && SBLANKn);
    if (PIXCE) begin
      m_color = old_pal[m_idx];
      for (int p = 0; p < PLANES; p++) m_idx[p] = (m_sft[p] >= 128);
    end
    for (int p = 0; p < PLANES; p++) begin
      if (clr || PLANE_DIS[p])   m_sft[p] = 0;
      else if (PIXCE && SFTLOD)  m_sft[p] = int'(VDATA[8*p +: 8]);
      else if (PIXCE)            m_sft[p] = (m_sft[p] * 2) % 256;
    end
  endtask

  // One clock: model the edge with the current inputs, then compare all outputs.
  task automatic cycle();
    model_edge();
    @(posedge CLKSYS);
    #1;
    check("busy",   32'(PAL_BUSY),   32'(m_busy));
    check("rvalid", 32'(PAL_RVALID), 32'(m_rvalid));
    check("rdata",  32'(PAL_RDATA),  32'(m_rdata));
    check("pixidx", 32'(PIXIDX),     32'(m_idx));
    check("color",  32'(COLOR),      32'(m_color));
  endtask

  task automatic quiet();
    PIXCE = 1'b0; SFTLOD = 1'b0; SVDOFFn = 1'b1; SBLANKn = 1'b1;
    PLANE_DIS = '0; VDATA = '0; PAL_WR = 1'b0; PAL_RD = 1'b0;
    PAL_ADDR = '0; PAL_WDATA = '0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_color"},  32'(COLOR),      32'd0);
    check({tag, "_pixidx"}, 32'(PIXIDX),     32'd0);
    check({tag, "_rdata"},  32'(PAL_RDATA),  32'd0);
    check({tag, "_rvalid"}, 32'(PAL_RVALID), 32'd0);
    check({tag, "_busy"},   32'(PAL_BUSY),   32'd1);
  endtask

  task automatic sweep(input string tag);
    for (int i = 0; i < DEPTH; i++) begin
      check({tag, "_busy_hi"}, 32'(PAL_BUSY), 32'd1);
      cycle();
    end
    check({tag, "_busy_lo"}, 32'(PAL_BUSY), 32'd0);
  endtask

  task automatic pal_read(input logic [2:0] addr, input logic [ENTRY_W-1:0] exp, input string tag);
    PAL_RD = 1'b1; PAL_ADDR = addr;
    cycle();
    PAL_RD = 1'b0;
    check({tag, "_data"},  32'(PAL_RDATA),  32'(exp));
    check({tag, "_valid"}, 32'(PAL_RVALID), 32'd1);
  endtask

  initial begin
    RESETBn = 1'b0;
    quiet();
    for (int i = 0; i < DEPTH; i++) m_pal[i] = 'x;
    model_reset();
    #12;
    check_reset_outputs("rst");
    @(posedge CLKSYS); #1;
    RESETBn = 1'b1;

    // 1: init sweep and default entries
    sweep("t1");
    pal_read(3'd5, 12'hF0F, "t1_rd5");
    cycle();
    check("t1_rvalid_pulse", 32'(PAL_RVALID), 32'd0);
    pal_read(3'd7, 12'hFFF, "t1_rd7");

    // 2: write then read, and read-first on a same-cycle collision
    PAL_WR = 1'b1; PAL_ADDR = 3'd2; PAL_WDATA = 12'h123;
    cycle();
    PAL_WR = 1'b0;
    pal_read(3'd2, 12'h123, "t2_rd2");
    cycle();
    check("t2_rdata_hold", 32'(PAL_RDATA), 32'h123);
    PAL_WR = 1'b1; PAL_RD = 1'b1; PAL_ADDR = 3'd3; PAL_WDATA = 12'hABC;
    cycle();
    PAL_WR = 1'b0; PAL_RD = 1'b0;
    check("t2_read_first", 32'(PAL_RDATA), 32'h0FF);

    // 3: single B pixel, two PIXCE of latency
    PIXCE = 1'b1; SFTLOD = 1'b1; VDATA = 24'h000080;
    cycle();
    SFTLOD = 1'b0; VDATA = '0;
    cycle();
    cycle();
    check("t3_first", 32'(COLOR), 32'h00F);
    for (int k = 1; k < 8; k++) begin
      cycle();
      check("t3_rest", 32'(COLOR), 32'h000);
    end

    // 4: blank mid-line clears the shifters
    SFTLOD = 1'b1; VDATA = 24'hFFFFFF;
    cycle();
    SFTLOD = 1'b0;
    for (int k = 0; k < 3; k++) cycle();
    SBLANKn = 1'b0;
    cycle();
    SBLANKn = 1'b1;
    check("t4_last_px", 32'(PIXIDX), 32'd7);
    cycle();
    check("t4_idx_clr", 32'(PIXIDX), 32'd0);
    check("t4_color_pre", 32'(COLOR), 32'hFFF);
    cycle();
    check("t4_color_clr", 32'(COLOR), 32'h000);

    // 5: plane 0 disabled
    PLANE_DIS = 3'b001; SFTLOD = 1'b1; VDATA = 24'hFFFFFF;
    cycle();
    SFTLOD = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      cycle();
      if (k <= 8) check("t5_idx", 32'(PIXIDX), 32'd6);
      if (k >= 2) check("t5_color", 32'(COLOR), 32'hFF0);
    end
    PLANE_DIS = '0;

    // Random traffic against the model
    for (int n = 0; n < 2000; n++) begin
      PIXCE     = ($urandom_range(0, 3) != 0);
      SFTLOD    = ($urandom_range(0, 7) == 0);
      SVDOFFn   = ($urandom_range(0, 15) != 0);
      SBLANKn   = ($urandom_range(0, 7) != 0);
      PLANE_DIS = ($urandom_range(0, 15) == 0) ? 3'($urandom) : 3'b000;
      VDATA     = 24'($urandom);
      PAL_WR    = ($urandom_range(0, 7) == 0);
      PAL_RD    = ($urandom_range(0, 3) == 0);
      PAL_ADDR  = 3'($urandom);
      PAL_WDATA = 12'($urandom);
      cycle();
    end

    // 6: reset asserted mid-sweep restarts the sweep
    quiet();
    #2;
    RESETBn = 1'b0;
    model_reset();
    #1;
    check_reset_outputs("t6_rst_a");
    @(posedge CLKSYS); #1;
    RESETBn = 1'b1;
    cycle();
    cycle();
    PAL_RD = 1'b1; PAL_ADDR = 3'd7;
    cycle();
    PAL_RD = 1'b0;
    check("t6_rd_busy", 32'(PAL_RVALID), 32'd1);
    RESETBn = 1'b0;
    model_reset();
    #1;
    check_reset_outputs("t6_rst_b");
    @(posedge CLKSYS); #1;
    RESETBn = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      check("t6_busy_hi", 32'(PAL_BUSY), 32'd1);
      PAL_WR = (i == 5); PAL_ADDR = 3'd0; PAL_WDATA = 12'h123;
      cycle();
    end
    PAL_WR = 1'b0;
    check("t6_busy_lo", 32'(PAL_BUSY), 32'd0);
    pal_read(3'd2, 12'h0F0, "t6_rd2");
    pal_read(3'd0, 12'h000, "t6_wr_busy");
    cycle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
